// File: rtl/dut_wrapper.sv
// dut_wrapper
// -----------
// Selectable arithmetic unit. It holds three purely combinational engines
// (ripple-carry adder, carry-lookahead adder, unsigned shift-add array
// multiplier). A run-time string selector, dut_type, chooses which engine
// feeds the single double-width result register.
//
// Ports:
//   clk     in   1        rising-edge clock
//   reset   in   1        asynchronous, active-low reset (0 = in reset)
//   a       in   WIDTH    operand A, unsigned
//   b       in   WIDTH    operand B, unsigned
//   result  out  2*WIDTH  registered result of the selected engine (1-cycle latency)
//
// dut_type is set to DEFAULT_TYPE and is meant to be overridden from a
// bench through a hierarchical assignment or force. Recognised values:
// "adder_rca", "adder_cla", "multiplier"/"mult"; anything else gives 0.

module dut_wrapper #(
  parameter int    WIDTH        = 8,
  parameter string DEFAULT_TYPE = "multiplier"
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);

  localparam int RW = 2 * WIDTH;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RCA  = 2'd1,
    OP_CLA  = 2'd2,
    OP_MUL  = 2'd3
  } op_t;

  string dut_type = DEFAULT_TYPE;

  op_t              op_p0;
  logic [WIDTH-1:0] rca_sum_p0;
  logic [WIDTH-1:0] cla_sum_p0;
  logic [RW-1:0]    mul_prod_p0;
  logic [RW-1:0]    sel_p0;

  // Carry-lookahead add in 4-bit groups. Inside a group every carry is
  // formed directly from the group's generate/propagate terms and the
  // group carry-in; groups are chained by ripple. A short final group
  // (WIDTH not a multiple of 4) is handled by the same bounds.
  function automatic logic [WIDTH-1:0] cla_add(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic             cout;
    logic             term;
    int               base;
    g = x & y;
    p = x ^ y;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      base = (i / 4) * 4;
      // Group carry-in propagated through every bit base..i.
      cout = c[base];
      for (int m = 0; m < WIDTH; m++)
        if (m >= base && m <= i) cout = cout & p[m];
      // Each generate k in the group propagated through bits k+1..i.
      for (int k = 0; k < WIDTH; k++) begin
        if (k >= base && k <= i) begin
          term = g[k];
          for (int m = 0; m < WIDTH; m++)
            if (m > k && m <= i) term = term & p[m];
          cout = cout | term;
        end
      end
      // Carry out of the top bit is dropped.
      if (i < WIDTH - 1) c[i+1] = cout;
    end
    return p ^ c;
  endfunction

  // Ripple adder over the full product width, used for the row
  // accumulation of the multiplier array.
  function automatic logic [RW-1:0] ripple_add_rw(input logic [RW-1:0] x,
                                                  input logic [RW-1:0] y);
    logic [RW-1:0] s;
    logic          c;
    c = 1'b0;
    for (int i = 0; i < RW; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return s;
  endfunction

  // ---- Stage p0: selector decode and combinational engines ----

  always_comb begin
    op_p0 = OP_NONE;
    if (dut_type == "adder_rca")
      op_p0 = OP_RCA;
    else if (dut_type == "adder_cla")
      op_p0 = OP_CLA;
    else if (dut_type == "multiplier" || dut_type == "mult")
      op_p0 = OP_MUL;
  end

  // Ripple-carry adder: chained full adders, carry-in 0, carry-out of
  // the top bit is never built.
  logic [WIDTH-1:0] rca_c;
  assign rca_c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    assign rca_sum_p0[i] = a[i] ^ b[i] ^ rca_c[i];
    if (i < WIDTH - 1) begin : g_carry
      assign rca_c[i+1] = (a[i] & b[i]) | (rca_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cla_sum_p0 = cla_add(a, b);

  // Array multiplier: row i is A gated by b[i], shifted into place,
  // then accumulated row by row.
  logic [RW-1:0] pp  [WIDTH];
  logic [RW-1:0] acc [WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_mul
    assign pp[i] = {{WIDTH{1'b0}}, (a & {WIDTH{b[i]}})} << i;
    if (i == 0) begin : g_first
      assign acc[i] = pp[i];
    end else begin : g_rest
      assign acc[i] = ripple_add_rw(acc[i-1], pp[i]);
    end
  end
  assign mul_prod_p0 = acc[WIDTH-1];

  always_comb begin
    sel_p0 = '0;
    case (op_p0)
      OP_RCA:  sel_p0 = {{WIDTH{1'b0}}, rca_sum_p0};
      OP_CLA:  sel_p0 = {{WIDTH{1'b0}}, cla_sum_p0};
      OP_MUL:  sel_p0 = mul_prod_p0;
      default: sel_p0 = '0;
    endcase
  end

  // ---- Stage p1: result register ----

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) result <= '0;
    else        result <= sel_p0;
  end

endmodule

// File: tb/tb_dut_wrapper.sv
// Testbench for dut_wrapper (WIDTH = 8). Scenario tasks run in sequence
// from one initial block and compare the registered result against
// constants or a behavioural arithmetic model.

module tb_dut_wrapper;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] result;

  int checks   = 0;
  int failures = 0;

  dut_wrapper #(.WIDTH(8), .DEFAULT_TYPE("multiplier")) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model(input string t, input int x, input int y);
    if (t == "adder_rca" || t == "adder_cla") return 16'((x + y) % 256);
    if (t == "multiplier" || t == "mult")     return 16'(x * y);
    return 16'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a = 8'd0;
    b = 8'd0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (result !== 16'd0) begin
      failures++;
      $display("FAIL reset_initial got=%0d want=0", result);
    end
    a = 8'd5;
    b = 8'd3;
    repeat (2) step();
    checks++;
    if (result !== 16'd0) begin
      failures++;
      $display("FAIL reset_hold got=%0d want=0", result);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++;
    if (result !== 16'd15) begin
      failures++;
      $display("FAIL default_type_mul got=%0d want=15", result);
    end
  endtask

  task automatic test_mul_directed();
    int ta[9] = '{5, 10, 15, 0, 255, 128, 1, 127, 255};
    int tb[9] = '{3, 4, 2, 100, 1, 128, 255, 129, 255};
    int te[9] = '{15, 40, 30, 0, 255, 16384, 255, 16383, 65025};
    dut.dut_type = "multiplier";
    for (int i = 0; i < 9; i++) begin
      a = 8'(ta[i]);
      b = 8'(tb[i]);
      step();
      checks++;
      if (result !== 16'(te[i])) begin
        failures++;
        $display("FAIL mul_first_edge %0d*%0d got=%0d want=%0d", ta[i], tb[i], result, te[i]);
      end
      step();
      checks++;
      if (result !== 16'(te[i])) begin
        failures++;
        $display("FAIL mul_held %0d*%0d got=%0d want=%0d", ta[i], tb[i], result, te[i]);
      end
    end
  endtask

  task automatic test_adders();
    string kinds[2] = '{"adder_rca", "adder_cla"};
    int ta[6] = '{5, 200, 255, 128, 127, 0};
    int tb[6] = '{3, 100, 1, 128, 129, 0};
    int te[6] = '{8, 44, 0, 0, 0, 0};
    for (int k = 0; k < 2; k++) begin
      dut.dut_type = kinds[k];
      for (int i = 0; i < 6; i++) begin
        a = 8'(ta[i]);
        b = 8'(tb[i]);
        repeat (2) step();
        checks++;
        if (result !== 16'(te[i])) begin
          failures++;
          $display("FAIL %s %0d+%0d got=%0d want=%0d", kinds[k], ta[i], tb[i], result, te[i]);
        end
      end
    end
  endtask

  task automatic test_selector_switch();
    a = 8'd10;
    b = 8'd4;
    dut.dut_type = "mult";
    step();
    checks++;
    if (result !== 16'd40) begin
      failures++;
      $display("FAIL sel_mult got=%0d want=40", result);
    end
    dut.dut_type = "adder_cla";
    #2;
    checks++;
    if (result !== 16'd40) begin
      failures++;
      $display("FAIL sel_before_edge got=%0d want=40", result);
    end
    step();
    checks++;
    if (result !== 16'd14) begin
      failures++;
      $display("FAIL sel_adder_cla got=%0d want=14", result);
    end
    dut.dut_type = "foo";
    step();
    checks++;
    if (result !== 16'd0) begin
      failures++;
      $display("FAIL sel_none got=%0d want=0", result);
    end
  endtask

  task automatic test_async_reset();
    dut.dut_type = "multiplier";
    a = 8'd127;
    b = 8'd129;
    step();
    checks++;
    if (result !== 16'd16383) begin
      failures++;
      $display("FAIL areset_pre got=%0d want=16383", result);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (result !== 16'd0) begin
      failures++;
      $display("FAIL areset_immediate got=%0d want=0", result);
    end
    a = 8'd5;
    b = 8'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (result !== 16'd0) begin
        failures++;
        $display("FAIL areset_hold cycle=%0d got=%0d want=0", i, result);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++;
    if (result !== 16'd15) begin
      failures++;
      $display("FAIL areset_release got=%0d want=15", result);
    end
  endtask

  task automatic test_random();
    string kinds[5] = '{"adder_rca", "adder_cla", "mult", "multiplier", "nope"};
    int pa;
    int pb;
    logic [15:0] exp;
    for (int k = 0; k < 5; k++) begin
      dut.dut_type = kinds[k];
      pa = int'($urandom_range(0, 255));
      pb = int'($urandom_range(0, 255));
      a = 8'(pa);
      b = 8'(pb);
      for (int n = 0; n < 1500; n++) begin
        step();
        exp = model(kinds[k], pa, pb);
        checks++;
        if (result !== exp) begin
          failures++;
          $display("FAIL rand_%s a=%0d b=%0d got=%0d want=%0d", kinds[k], pa, pb, result, exp);
        end
        case ($urandom_range(0, 7))
          0:       begin pa = 255; pb = int'($urandom_range(0, 255)); end
          1:       begin pa = int'($urandom_range(0, 255)); pb = 255; end
          2:       begin pa = 255; pb = 255; end
          3:       begin pa = 0;   pb = int'($urandom_range(0, 255)); end
          default: begin pa = int'($urandom_range(0, 255)); pb = int'($urandom_range(0, 255)); end
        endcase
        a = 8'(pa);
        b = 8'(pb);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    a = 8'd0;
    b = 8'd0;
    test_reset();
    test_mul_directed();
    test_adders();
    test_selector_switch();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
